stim_pulse_gen: RTL
===================

Name: stim_pulse_gen

Overview:
- Consumes the seizure-detection decision (stim_req / req_valid) from the feature-voting controller.
- Converts each accepted decision into a charge-balanced biphasic pulse train for the stimulator front end.
- Enforces a fixed pulse timing, a fixed train length and a refractory lockout.
- Counts decisions that arrive while a train is already in progress.

Parameters:
- PHASE_W, 4: cycles per phase (positive and negative); ≥1.
- GAP_W, 2: interphase gap in cycles; 0 allowed, meaning no gap.
- PERIOD, 20: pulse start-to-start spacing in cycles; must satisfy PERIOD ≥ 2*PHASE_W+GAP_W+1.
- NUM_PULSES, 3: pulses per train; ≥1.
- REFRACT, 50: lockout cycles after each train; ≥1.
- CNT_WIDTH, 16: width of all internal timers.
- DROP_WIDTH, 8: width of the dropped-request counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- stim_req  input  1  detection decision, meaningful only when req_valid=1.
- req_valid  input  1  one-cycle strobe: all feature outputs ready, decision valid.
- stim_abort  input  1  safety abort, level-sensitive.
- phase_pos  output  1  anodic phase drive, registered.
- phase_neg  output  1  cathodic phase drive, registered.
- train_active  output  1  high from first POS cycle through last NEG cycle.
- refractory  output  1  high during lockout.
- pulse_idx  output  $clog2(NUM_PULSES+1)  pulses completed in the current train.
- drop_cnt  output  DROP_WIDTH  accepted-style requests (req_valid & stim_req) seen while not IDLE; saturating.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset: state=IDLE; phase_pos, phase_neg, train_active and refractory are 0; pulse_idx=0; drop_cnt=0; all timers 0.
- Reset mid-train forces both phase outputs low on that edge; charge balance is not completed.
- All outputs are registered.
- phase_pos and phase_neg are never high in the same cycle (checked by assertion).

States:
- IDLE: on an edge with req_valid & stim_req, go to POS. phase_pos is high in the cycle immediately after the sampling edge (1-cycle latency).
- POS: PHASE_W cycles, phase_pos=1. Then go to GAP, or to NEG if GAP_W=0.
- GAP: GAP_W cycles, both phases 0. Then NEG.
- NEG: PHASE_W cycles, phase_neg=1. On exit, pulse_idx increments. If pulse_idx reaches NUM_PULSES or an abort is latched, go to REFR; otherwise go to REST.
- REST: PERIOD - (2*PHASE_W+GAP_W) cycles, both phases 0. Then POS. The start of each POS is exactly PERIOD cycles after the previous POS start.
- REFR: REFRACT cycles, refractory=1, train_active=0. Then IDLE, with pulse_idx cleared to 0 on entry to IDLE.

Request and drop handling:
- stim_req is ignored when req_valid=0.
- In any state other than IDLE, req_valid & stim_req increments drop_cnt.
- drop_cnt saturates at all-ones.
- Requests are not queued.
- A request on the same edge that REFR→IDLE occurs counts as dropped and does not start a train.

Abort handling:
- stim_abort in POS or GAP sets an abort latch. The current pulse completes GAP and NEG (charge balance), then goes to REFR.
- stim_abort in NEG finishes NEG, then goes to REFR.
- stim_abort in REST goes to REFR on the next edge.
- stim_abort in IDLE or REFR has no effect. An IDLE request with stim_abort=1 on the same edge is not started and not counted.
- The abort latch clears on REFR entry.

Timers:
- Each state is timed by a down-counter loaded on state entry. State exit occurs when the counter reaches 1.

Test Plan:
- Default parameters; one request strobe at edge 10 -> phase_pos high in cycles 11-14, gap in 15-16, phase_neg high in 17-20. Pulses start at cycles 11, 31 and 51. train_active falls after cycle 60. refractory is high in cycles 61-110. IDLE in cycle 111. pulse_idx reads 3 during REFR.
- Request strobes at cycles 25 and 70 during a train started at cycle 10 -> drop_cnt=2, no extra pulses. A strobe at cycle 120 starts a new train.
- stim_abort pulsed in the 2nd cycle of pulse 2's POS -> POS, GAP and NEG of pulse 2 complete (4/2/4 cycles), then REFR. pulse_idx=2. Total phase_pos cycles equal total phase_neg cycles (8 each).
- stim_abort during REST after pulse 1 -> REFR on the next edge, no further phase activity. pulse_idx=1.
- GAP_W=0, PERIOD=9, NUM_PULSES=2 -> phase_neg immediately follows phase_pos. Second POS starts 9 cycles after the first.
- rst asserted during NEG of pulse 1 -> next cycle all outputs 0 and drop_cnt=0. A strobe 2 cycles later starts a normal train. 300 strobes while busy -> drop_cnt=255.

Source files
------------

// File: rtl/stim_pulse_gen_if.sv
// Request/abort inputs and pulse-train outputs of the stimulation pulse generator.
// master: decision source / bench (drives stim_req, req_valid, stim_abort).
// slave : stim_pulse_gen (drives phase_pos, phase_neg, train_active,
//         refractory, pulse_idx, drop_cnt).
interface stim_pulse_gen_if #(
  parameter int unsigned NUM_PULSES = 3,
  parameter int unsigned DROP_WIDTH = 8
);
  localparam int unsigned IDX_W = $clog2(NUM_PULSES + 1);

  logic                  stim_req;
  logic                  req_valid;
  logic                  stim_abort;
  logic                  phase_pos;
  logic                  phase_neg;
  logic                  train_active;
  logic                  refractory;
  logic [IDX_W-1:0]      pulse_idx;
  logic [DROP_WIDTH-1:0] drop_cnt;

  modport master (
    output stim_req, req_valid, stim_abort,
    input  phase_pos, phase_neg, train_active, refractory, pulse_idx, drop_cnt
  );

  modport slave (
    input  stim_req, req_valid, stim_abort,
    output phase_pos, phase_neg, train_active, refractory, pulse_idx, drop_cnt
  );
endinterface

// File: rtl/stim_pulse_gen.sv
// Charge-balanced biphasic pulse-train generator with refractory lockout.
// Ports: clk, rst (sync, active-high), bus (slave modport of stim_pulse_gen_if):
//   stim_req/req_valid  detection decision and its one-cycle strobe
//   stim_abort          level-sensitive safety abort
//   phase_pos/phase_neg anodic/cathodic drive (registered, mutually exclusive)
//   train_active        first POS cycle through last NEG cycle
//   refractory          lockout after each train
//   pulse_idx           pulses completed in the current train
//   drop_cnt            saturating count of requests seen while busy
module stim_pulse_gen #(
  parameter int unsigned PHASE_W    = 4,
  parameter int unsigned GAP_W      = 2,
  parameter int unsigned PERIOD     = 20,
  parameter int unsigned NUM_PULSES = 3,
  parameter int unsigned REFRACT    = 50,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned DROP_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  stim_pulse_gen_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(NUM_PULSES + 1);

  localparam logic [CNT_WIDTH-1:0] T_PHASE = CNT_WIDTH'(PHASE_W);
  localparam logic [CNT_WIDTH-1:0] T_GAP   = CNT_WIDTH'(GAP_W);
  localparam logic [CNT_WIDTH-1:0] T_REST  = CNT_WIDTH'(PERIOD - 2 * PHASE_W - GAP_W);
  localparam logic [CNT_WIDTH-1:0] T_REFR  = CNT_WIDTH'(REFRACT);
  localparam logic [CNT_WIDTH-1:0] T_ONE   = CNT_WIDTH'(1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_PULSES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POS,
    S_GAP,
    S_NEG,
    S_REST,
    S_REFR
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  timer_q, timer_d;
  logic [IDX_W-1:0]      pulse_idx_q, pulse_idx_d;
  logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                  abort_q, abort_d;
  logic                  phase_pos_q, phase_pos_d;
  logic                  phase_neg_q, phase_neg_d;
  logic                  train_active_q, train_active_d;
  logic                  refractory_q, refractory_d;

  logic req;
  logic timer_done;

  assign req        = bus.req_valid & bus.stim_req;
  assign timer_done = (timer_q == T_ONE);

  // Next-state, timer, pulse count, abort latch and drop counter.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pulse_idx_d = pulse_idx_q;
    abort_d     = abort_q;
    drop_cnt_d  = drop_cnt_q;

    // Busy-state requests are counted, never queued; includes the REFR->IDLE edge.
    if ((state_q != S_IDLE) && req && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_WIDTH'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (req && !bus.stim_abort) begin
          state_d = S_POS;
          timer_d = T_PHASE;
        end
      end

      S_POS: begin
        if (bus.stim_abort) abort_d = 1'b1;
        if (timer_done) begin
          if (GAP_W > 0) begin
            state_d = S_GAP;
            timer_d = T_GAP;
          end else begin
            state_d = S_NEG;
            timer_d = T_PHASE;
          end
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end

      S_GAP: begin
        if (bus.stim_abort) abort_d = 1'b1;
        if (timer_done) begin
          state_d = S_NEG;
          timer_d = T_PHASE;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end

      // NEG always runs to completion so every pulse stays charge balanced.
      S_NEG: begin
        if (bus.stim_abort) abort_d = 1'b1;
        if (timer_done) begin
          pulse_idx_d = pulse_idx_q + IDX_W'(1);
          if ((pulse_idx_d == LAST_IDX) || abort_q || bus.stim_abort) begin
            state_d = S_REFR;
            timer_d = T_REFR;
            abort_d = 1'b0;
          end else begin
            state_d = S_REST;
            timer_d = T_REST;
          end
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end

      // No phase is in flight during REST, so an abort takes effect at once.
      S_REST: begin
        if (bus.stim_abort) begin
          state_d = S_REFR;
          timer_d = T_REFR;
          abort_d = 1'b0;
        end else if (timer_done) begin
          state_d = S_POS;
          timer_d = T_PHASE;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end

      S_REFR: begin
        if (timer_done) begin
          state_d     = S_IDLE;
          timer_d     = '0;
          pulse_idx_d = '0;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        timer_d     = '0;
        pulse_idx_d = '0;
        abort_d     = 1'b0;
      end
    endcase

    // Outputs decoded from the next state so they register with it.
    phase_pos_d    = (state_d == S_POS);
    phase_neg_d    = (state_d == S_NEG);
    train_active_d = (state_d == S_POS) || (state_d == S_GAP) ||
                     (state_d == S_NEG) || (state_d == S_REST);
    refractory_d   = (state_d == S_REFR);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      pulse_idx_q    <= '0;
      drop_cnt_q     <= '0;
      abort_q        <= 1'b0;
      phase_pos_q    <= 1'b0;
      phase_neg_q    <= 1'b0;
      train_active_q <= 1'b0;
      refractory_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      pulse_idx_q    <= pulse_idx_d;
      drop_cnt_q     <= drop_cnt_d;
      abort_q        <= abort_d;
      phase_pos_q    <= phase_pos_d;
      phase_neg_q    <= phase_neg_d;
      train_active_q <= train_active_d;
      refractory_q   <= refractory_d;
    end
  end

  assign bus.phase_pos    = phase_pos_q;
  assign bus.phase_neg    = phase_neg_q;
  assign bus.train_active = train_active_q;
  assign bus.refractory   = refractory_q;
  assign bus.pulse_idx    = pulse_idx_q;
  assign bus.drop_cnt     = drop_cnt_q;

  // Both electrodes driven at once would short the stimulator output stage.
  phase_exclusive_a: assert property (@(posedge clk) disable iff (rst)
    !(phase_pos_q && phase_neg_q));

endmodule
